// File: rtl/execute_seq_if.sv
// execute_seq_if: command handshake channel into the operand sequencer
interface execute_seq_if #(
  parameter int OP_SEL_WIDTH = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH = 4
);
  logic cmd_valid;
  logic cmd_ready;
  logic [OP_SEL_WIDTH-1:0] cmd_op;
  logic cmd_dot;
  logic [LEN_WIDTH-1:0] cmd_len;
  logic [ADDR_WIDTH-1:0] cmd_src_a;
  logic [ADDR_WIDTH-1:0] cmd_src_b;
  logic [ADDR_WIDTH-1:0] cmd_dst;
  modport master (
    output cmd_valid, cmd_op, cmd_dot, cmd_len, cmd_src_a, cmd_src_b, cmd_dst,
    input  cmd_ready
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_dot, cmd_len, cmd_src_a, cmd_src_b, cmd_dst,
    output cmd_ready
  );
endinterface

// File: rtl/execute_seq.sv
// execute_seq: command-driven operand sequencer feeding execute_unit from the vector register file
module execute_seq #(
  parameter int PE_COUNT = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH = 4,
  parameter int EXEC_CYCLES = 2,
  parameter int OP_SEL_WIDTH = 2
) (
  input  logic clk,
  input  logic rstn,
  execute_seq_if.slave cmd,
  output logic rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [ADDR_WIDTH-1:0] rd_addr_b,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] rd_data_a,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] rd_data_b,
  output logic [PE_COUNT*DATA_WIDTH-1:0] a,
  output logic [PE_COUNT*DATA_WIDTH-1:0] b,
  output logic [OP_SEL_WIDTH-1:0] pe_op,
  output logic dot_prod_en,
  output logic shift,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] elem_out,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] dot_out,
  output logic wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [PE_COUNT*DATA_WIDTH-1:0] wr_data,
  output logic busy,
  output logic done
);
  localparam int CW = EXEC_CYCLES > 1 ? $clog2(EXEC_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, READ, LOAD, EXEC, WRITE, FINISH} state_t;
  state_t state;
  logic [OP_SEL_WIDTH-1:0] op_q;
  logic dot_q;
  logic [LEN_WIDTH-1:0] len_q, k, k_nx;
  logic [ADDR_WIDTH-1:0] src_a_q, src_b_q, dst_q;
  logic [CW-1:0] cnt;
  logic last, ex_last;
  assign k_nx = k + LEN_WIDTH'(1);
  assign last = k == len_q - LEN_WIDTH'(1);
  assign ex_last = cnt == CW'(EXEC_CYCLES - 1);
  assign cmd.cmd_ready = rstn && state == IDLE;
  assign busy = state != IDLE;
  assign wr_data = wr_en ? (dot_q ? dot_out : elem_out) : '0;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      op_q <= '0;
      dot_q <= 1'b0;
      len_q <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q <= '0;
      k <= '0;
      cnt <= '0;
      a <= '0;
      b <= '0;
      pe_op <= '0;
      dot_prod_en <= 1'b0;
      shift <= 1'b0;
      rd_en <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      done <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      wr_en <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (cmd.cmd_valid) begin
          op_q <= cmd.cmd_op;
          dot_q <= cmd.cmd_dot;
          len_q <= cmd.cmd_len;
          src_a_q <= cmd.cmd_src_a;
          src_b_q <= cmd.cmd_src_b;
          dst_q <= cmd.cmd_dst;
          pe_op <= cmd.cmd_op;
          k <= '0;
          if (cmd.cmd_len == '0) begin
            state <= FINISH;
            done <= 1'b1;
          end else begin
            state <= READ;
            rd_en <= 1'b1;
            rd_addr_a <= cmd.cmd_src_a;
            rd_addr_b <= cmd.cmd_src_b;
            dot_prod_en <= cmd.cmd_dot;
          end
        end
        READ: state <= LOAD;
        LOAD: begin
          a <= rd_data_a;
          b <= rd_data_b;
          cnt <= '0;
          shift <= dot_q && k == '0;
          state <= EXEC;
        end
        EXEC: if (!ex_last) cnt <= cnt + CW'(1);
        else begin
          shift <= 1'b0;
          if (dot_q && !last) begin
            k <= k_nx;
            state <= READ;
            rd_en <= 1'b1;
            rd_addr_a <= src_a_q + ADDR_WIDTH'(k_nx);
            rd_addr_b <= src_b_q + ADDR_WIDTH'(k_nx);
          end else begin
            state <= WRITE;
            wr_en <= 1'b1;
            wr_addr <= dot_q ? dst_q : dst_q + ADDR_WIDTH'(k);
          end
        end
        WRITE: if (dot_q || last) begin
          state <= FINISH;
          done <= 1'b1;
          dot_prod_en <= 1'b0;
        end else begin
          k <= k_nx;
          state <= READ;
          rd_en <= 1'b1;
          rd_addr_a <= src_a_q + ADDR_WIDTH'(k_nx);
          rd_addr_b <= src_b_q + ADDR_WIDTH'(k_nx);
        end
        FINISH: begin
          state <= IDLE;
          pe_op <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_execute_seq.sv
// tb_execute_seq: directed cycle-accurate checks of execute_seq against hand-computed traces
module tb_execute_seq;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  execute_seq_if #(.OP_SEL_WIDTH(2), .ADDR_WIDTH(8), .LEN_WIDTH(4)) cmd_if ();
  logic rd_en, wr_en, dot_prod_en, shift, busy, done;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [W-1:0] rd_data_a, rd_data_b, a, b, elem_out, dot_out, wr_data;
  logic [1:0] pe_op;
  logic [W-1:0] rf [256];
  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] m_rd, m_wr, m_done, m_shift, m_dpe, m_rdy;
  logic [7:0] t_ra [32];
  logic [7:0] t_wa [32];
  logic [W-1:0] t_wd [32];
  logic [W-1:0] t_a [32];
  logic [1:0] t_op [32];
  execute_seq #(
    .PE_COUNT(4), .DATA_WIDTH(8), .ADDR_WIDTH(8), .LEN_WIDTH(4), .EXEC_CYCLES(2), .OP_SEL_WIDTH(2)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .cmd(cmd_if.slave),
    .rd_en(rd_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b),
    .a(a),
    .b(b),
    .pe_op(pe_op),
    .dot_prod_en(dot_prod_en),
    .shift(shift),
    .elem_out(elem_out),
    .dot_out(dot_out),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) begin
    rd_data_a <= rf[rd_addr_a];
    rd_data_b <= rf[rd_addr_b];
  end
  always_comb begin
    elem_out = '0;
    for (int i = 0; i < 4; i++)
      elem_out[i*8+:8] = pe_op == 2'd0 ? b[i*8+:8] :
                         pe_op == 2'd1 ? a[i*8+:8] + b[i*8+:8] :
                         pe_op == 2'd2 ? a[i*8+:8] - b[i*8+:8] : a[i*8+:8] * b[i*8+:8];
  end
  assign dot_out = 32'hCAFE0004;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [1:0] op, input logic dot, input logic [3:0] len,
                     input logic [7:0] sa, input logic [7:0] sb, input logic [7:0] dst,
                     input int n, input int drop_at, input int abort_at);
    @(negedge clk);
    cmd_if.cmd_op = op;
    cmd_if.cmd_dot = dot;
    cmd_if.cmd_len = len;
    cmd_if.cmd_src_a = sa;
    cmd_if.cmd_src_b = sb;
    cmd_if.cmd_dst = dst;
    cmd_if.cmd_valid = 1'b1;
    check("accept_ready", cmd_if.cmd_ready, 1);
    m_rd = '0; m_wr = '0; m_done = '0; m_shift = '0; m_dpe = '0; m_rdy = '0;
    @(posedge clk);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      m_rd[c] = rd_en;
      m_wr[c] = wr_en;
      m_done[c] = done;
      m_shift[c] = shift;
      m_dpe[c] = dot_prod_en;
      m_rdy[c] = cmd_if.cmd_ready;
      t_ra[c] = rd_addr_a;
      t_wa[c] = wr_addr;
      t_wd[c] = wr_data;
      t_a[c] = a;
      t_op[c] = pe_op;
      if (c == drop_at) cmd_if.cmd_valid = 1'b0;
      if (c == abort_at) rstn = 1'b0;
      if (abort_at > 0 && c == abort_at + 2) rstn = 1'b1;
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) rf[i] = '0;
    rf[8'h10] = 32'h04030201; rf[8'h20] = 32'h40302010;
    rf[8'h11] = 32'h01010101; rf[8'h21] = 32'h02020202;
    for (int i = 0; i < 4; i++) begin
      rf[8'h40 + i] = 32'h01010101;
      rf[8'h50 + i] = 32'h01010101;
    end
    rf[8'hFF] = 32'h11111111; rf[8'h00] = 32'h22222222;
    rf[8'h70] = 32'h12345678; rf[8'h71] = 32'h9ABCDEF0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op = 2'd1; cmd_if.cmd_dot = 1'b0; cmd_if.cmd_len = 4'd1;
    cmd_if.cmd_src_a = '0; cmd_if.cmd_src_b = '0; cmd_if.cmd_dst = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_if.cmd_ready, 0);
    check("rst_ctrl", {rd_en, wr_en, done, busy, dot_prod_en, shift, pe_op, wr_addr}, 0);
    check("rst_ab", {a, b}, 0);
    check("rst_wdata", wr_data, 0);
    cmd_if.cmd_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    check("rel_ready", cmd_if.cmd_ready, 1);
    check("rel_busy", busy, 0);
    run(2'b01, 1'b0, 4'd2, 8'h10, 8'h20, 8'h30, 12, 1, 0);
    check("add_rd", m_rd, 64'h42);
    check("add_wr", m_wr, 64'h420);
    check("add_done", m_done, 64'h800);
    check("add_dpe", m_dpe, 0);
    check("add_ra1", t_ra[1], 8'h10);
    check("add_ra6", t_ra[6], 8'h11);
    check("add_wa5", t_wa[5], 8'h30);
    check("add_wd5", t_wd[5], 32'h44332211);
    check("add_wa10", t_wa[10], 8'h31);
    check("add_wd10", t_wd[10], 32'h03030303);
    check("add_op3", t_op[3], 2'd1);
    check("add_op_idle", t_op[12], 2'd0);
    run(2'b11, 1'b1, 4'd4, 8'h40, 8'h50, 8'h60, 20, 1, 0);
    check("dot_shift", m_shift, 64'h18);
    check("dot_dpe", m_dpe, 64'h3FFFE);
    check("dot_rd", m_rd, 64'h2222);
    check("dot_wr", m_wr, 64'h20000);
    check("dot_done", m_done, 64'h40000);
    check("dot_wa", t_wa[17], 8'h60);
    check("dot_wd", t_wd[17], 32'hCAFE0004);
    check("dot_a3", t_a[3], 32'h01010101);
    run(2'b01, 1'b0, 4'd0, 8'h10, 8'h20, 8'h30, 4, 1, 0);
    check("zero_done", m_done, 64'h2);
    check("zero_rd", m_rd, 0);
    check("zero_wr", m_wr, 0);
    check("zero_rdy", m_rdy, 64'h1C);
    run(2'b00, 1'b0, 4'd2, 8'hFF, 8'h70, 8'h80, 24, 13, 0);
    check("wrap_rd", m_rd, 64'h42042);
    check("wrap_rdy", m_rdy, 64'h1001000);
    check("wrap_done", m_done, 64'h800800);
    check("wrap_ra1", t_ra[1], 8'hFF);
    check("wrap_ra6", t_ra[6], 8'h00);
    check("wrap_ra13", t_ra[13], 8'hFF);
    check("wrap_wd5", t_wd[5], 32'h12345678);
    check("wrap_wd10", t_wd[10], 32'h9ABCDEF0);
    check("wrap_wa10", t_wa[10], 8'h81);
    run(2'b01, 1'b0, 4'd2, 8'h10, 8'h20, 8'h30, 14, 1, 8);
    check("abort_rd", m_rd, 64'h42);
    check("abort_wr", m_wr, 64'h20);
    check("abort_done", m_done, 0);
    check("abort_busy", busy, 0);
    run(2'b01, 1'b0, 4'd2, 8'h10, 8'h20, 8'h30, 12, 1, 0);
    check("post_done", m_done, 64'h800);
    check("post_wr", m_wr, 64'h420);
    check("post_wd5", t_wd[5], 32'h44332211);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
